// File: rtl/flits_serializer_pkg.sv
// Shared constants and types for the NIC flit serializer.
package flits_serializer_pkg;

   localparam int FLIT_WIDTH        = 8;
   localparam int MAX_PACKET_LENGHT = 8;
   localparam int ROUTER_CREDITS    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/flits_serializer_if.sv
// Packet-in / flit-out bus between the NIC packet source, the serializer and the router port.
interface flits_serializer_if;
   import flits_serializer_pkg::*;

   logic                                    r_pkt_i;
   logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i;
   logic [MAX_PACKET_LENGHT-1:0]            in_sel_i;
   logic                                    g_pkt_o;
   logic [FLIT_WIDTH-1:0]                   out_link_o;
   logic                                    is_valid_o;
   logic                                    credit_signal_i;
   logic                                    free_signal_i;

   // The serializer is the slave: it is requested upstream and returns flits.
   modport slave (
      input  r_pkt_i, in_link_i, in_sel_i, credit_signal_i, free_signal_i,
      output g_pkt_o, out_link_o, is_valid_o
   );

   modport master (
      output r_pkt_i, in_link_i, in_sel_i, credit_signal_i, free_signal_i,
      input  g_pkt_o, out_link_o, is_valid_o
   );

endinterface

// File: rtl/flits_serializer_credit_counter.sv
// Router flit-slot credit counter: saturates at MAX_CREDITS, inc and dec together cancel.
module credit_counter #(
   parameter int N_BITS_CREDIT = 4,
   parameter int MAX_CREDITS   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc_i,
   input  logic                     dec_i,
   output logic [N_BITS_CREDIT-1:0] count_o,
   output logic                     zero_o
);

   localparam logic [N_BITS_CREDIT-1:0] CNT_MAX = N_BITS_CREDIT'(MAX_CREDITS);
   localparam logic [N_BITS_CREDIT-1:0] CNT_ONE = N_BITS_CREDIT'(1);

   logic [N_BITS_CREDIT-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= CNT_MAX;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/flits_serializer.sv
// Captures a whole packet on grant and emits it one flit per cycle toward the
// router, pausing whenever the router has no free flit slot (credit).
module flits_serializer
   import flits_serializer_pkg::*;
#(
   parameter int N_BITS_POINTER = $clog2(MAX_PACKET_LENGHT),
   parameter int N_BITS_CREDIT  = $clog2(ROUTER_CREDITS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   flits_serializer_if.slave  bus
);

   localparam int PKT_W = MAX_PACKET_LENGHT * FLIT_WIDTH;
   localparam logic [N_BITS_POINTER-1:0] PTR_LAST = N_BITS_POINTER'(MAX_PACKET_LENGHT - 1);
   localparam logic [N_BITS_POINTER-1:0] PTR_ONE  = N_BITS_POINTER'(1);

   state_e                    state_d, state_q;
   logic [N_BITS_POINTER-1:0] ptr_d, ptr_q, ptr_inc;
   logic [PKT_W-1:0]          pkt_d, pkt_q;
   logic [MAX_PACKET_LENGHT-1:0] sel_d, sel_q;
   logic [FLIT_WIDTH-1:0]     out_link_d, out_link_q;
   logic                      is_valid_d, is_valid_q;
   logic                      grant, send, last_flit, cred_zero;
   logic [N_BITS_CREDIT-1:0]  cred_count;

   credit_counter #(
      .N_BITS_CREDIT (N_BITS_CREDIT),
      .MAX_CREDITS   (ROUTER_CREDITS)
   ) u_credit (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (bus.credit_signal_i),
      .dec_i   (send),
      .count_o (cred_count),
      .zero_o  (cred_zero)
   );

   always_comb assert (cred_zero == (cred_count == '0));

   // The mask is contiguous, so the first cleared bit past ptr marks the tail.
   assign ptr_inc   = ptr_q + PTR_ONE;
   assign last_flit = (ptr_q == PTR_LAST) || !sel_q[ptr_inc];
   assign send      = (state_q == SEND) && !cred_zero;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      pkt_d      = pkt_q;
      sel_d      = sel_q;
      out_link_d = out_link_q;
      is_valid_d = 1'b0;
      grant      = 1'b0;
      case (state_q)
         IDLE: begin
            grant = bus.r_pkt_i && bus.free_signal_i && (bus.in_sel_i != '0);
            if (grant) begin
               pkt_d   = bus.in_link_i;
               sel_d   = bus.in_sel_i;
               ptr_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (send) begin
               out_link_d = pkt_q[int'(ptr_q) * FLIT_WIDTH +: FLIT_WIDTH];
               is_valid_d = 1'b1;
               ptr_d      = ptr_inc;
               if (last_flit) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         pkt_q      <= '0;
         sel_q      <= '0;
         out_link_q <= '0;
         is_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         pkt_q      <= pkt_d;
         sel_q      <= sel_d;
         out_link_q <= out_link_d;
         is_valid_q <= is_valid_d;
      end
   end

   // Grant is combinational from IDLE, so it must be masked while reset is held.
   assign bus.g_pkt_o    = grant && rst;
   assign bus.out_link_o = out_link_q;
   assign bus.is_valid_o = is_valid_q;

endmodule

// File: doc/flits_serializer.md
FLITS_SERIALIZER -- requirements
Module: flits_serializer

Interface
REQ-001 SHALL have parameter N_BITS_POINTER, default clog2(`MAX_PACKET_LENGHT), flit index width.
REQ-002 SHALL have parameter N_BITS_CREDIT, default clog2(`ROUTER_CREDITS+1), credit counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port r_pkt_i, input, 1, upstream request: a packet is presented.
REQ-006 SHALL have port in_link_i, input, `MAX_PACKET_LENGHT*`FLIT_WIDTH, packet flits, flit k at bits [k*`FLIT_WIDTH +: `FLIT_WIDTH].
REQ-007 SHALL have port in_sel_i, input, `MAX_PACKET_LENGHT, valid-flit mask, contiguous from bit 0.
REQ-008 SHALL have port g_pkt_o, output, 1, grant: packet captured this cycle.
REQ-009 SHALL have port out_link_o, output, `FLIT_WIDTH, flit toward router input port.
REQ-010 SHALL have port is_valid_o, output, 1, out_link_o carries a valid flit.
REQ-011 SHALL have port credit_signal_i, input, 1, one-cycle pulse, router freed one flit slot.
REQ-012 SHALL have port free_signal_i, input, 1, router input buffer accepts a new packet.

Function
REQ-013 SHALL implement FSM states IDLE and SEND.
REQ-014 In IDLE, g_pkt_o SHALL be combinationally 1 iff r_pkt_i=1, free_signal_i=1, in_sel_i!=0.
REQ-015 On a grant edge, in_link_i and in_sel_i SHALL be latched, flit pointer cleared to 0, state -> SEND.
REQ-016 r_pkt_i=1 with in_sel_i=0 SHALL be ignored: no grant, state stays IDLE.
REQ-017 In SEND with credit count>0, each edge SHALL register out_link_o<=flit[ptr], is_valid_o<=1, decrement credit, increment ptr.
REQ-018 In SEND with credit count=0, is_valid_o SHALL be 0 on next edge; ptr and flit data held.
REQ-019 Last flit SHALL be index ptr where ptr=`MAX_PACKET_LENGHT-1 or latched sel[ptr+1]=0; after sending it state -> IDLE.
REQ-020 In IDLE, is_valid_o SHALL register 0; out_link_o SHALL hold its last value.
REQ-021 First flit SHALL appear on out_link_o/is_valid_o exactly one cycle after the grant edge (no credit stall).
REQ-022 Flit contents SHALL pass unmodified (type code in low nibble: 4 head, 1 body, 2 tail, 3 head_tail).
REQ-023 Credit counter SHALL increment on credit_signal_i, decrement on flit send; both in same cycle -> unchanged.
REQ-024 Credit counter SHALL saturate at `ROUTER_CREDITS; credit_signal_i at maximum is ignored.
REQ-025 Back-to-back packets SHALL be possible with exactly one IDLE cycle between tail and next head.

Reset
REQ-026 While rst=0: state=IDLE, ptr=0, credit=`ROUTER_CREDITS, is_valid_o=0, out_link_o=0, latched packet=0.
REQ-027 Reset asserted mid-packet SHALL drop the packet immediately; g_pkt_o=0 during reset.

Structure
REQ-028 `FLIT_WIDTH, `MAX_PACKET_LENGHT, `ROUTER_CREDITS SHALL live in NIC-defines.v; clog2 from NIC_utils.vh.
REQ-029 Credit counter SHALL be a sub-module credit_counter (inc, dec, count, zero flag).
REQ-030 Total RTL SHALL be 120-400 lines; no other sub-modules.

Verification
REQ-031 5-flit packet 04,A1,B1,C1,D2, sel=5'b11111, credits=8 -> grant 1 cycle, flits on 5 consecutive cycles starting 1 cycle later, credit=3.
REQ-032 1-flit packet F3, sel=1 -> one flit F3 with is_valid_o=1 for one cycle, return to IDLE.
REQ-033 credits=2, 4-flit packet, no credit returns -> 2 flits, is_valid_o=0 stall; pulse credit_signal_i twice -> remaining 2 flits follow.
REQ-034 free_signal_i=0 with r_pkt_i=1 -> no grant; raise free_signal_i -> grant next cycle.
REQ-035 credit_signal_i coincident with each send -> credit count constant; credit pulse at max -> count unchanged.
REQ-036 rst=0 after 2nd flit of 5 -> is_valid_o=0 asynchronously, credit=`ROUTER_CREDITS, next packet starts from flit 0.
